// File: rtl/ifu_pkg.sv
// ifu_pkg: shared instruction-fetch types and constants.
package ifu_pkg;
  typedef logic [15:0] half_t;
  localparam int DEPTH = 3;
  localparam logic [1:0] OP32 = 2'b11;
endpackage

// File: rtl/instr_align.sv
// instr_align: realigns a 32-bit fetch word stream into 16/32-bit RISC-V instructions.
module instr_align
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        fetch_valid,
  output logic        fetch_ready,
  input  logic [31:0] fetch_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  output logic        instr_compressed
);
  half_t hw [DEPTH];
  half_t sh [DEPTH];
  half_t nx [DEPTH];
  half_t first;
  logic [1:0] count, n_push, n_pop, base, base1;
  logic [31:0] pc;
  logic skip_low, comp, push_fire, pop_fire, unused_pc0;
  assign unused_pc0 = redirect_pc[0];
  assign comp = hw[0][1:0] != OP32;
  // rst_n gating keeps the fetch side quiet for the whole reset pulse
  assign fetch_ready = rst_n && count <= 2'd1 && !redirect;
  assign instr_valid = !redirect && ((count != 2'd0 && comp) || count >= 2'd2);
  assign instr_out = comp ? {16'h0, hw[0]} : {hw[1], hw[0]};
  assign instr_compressed = comp;
  assign instr_pc = pc;
  assign push_fire = fetch_valid && fetch_ready;
  assign pop_fire = instr_valid && instr_ready;
  assign n_push = push_fire ? (skip_low ? 2'd1 : 2'd2) : 2'd0;
  assign n_pop = pop_fire ? (comp ? 2'd1 : 2'd2) : 2'd0;
  assign base = count - n_pop;
  assign base1 = base + 2'd1;
  assign first = skip_low ? fetch_data[31:16] : fetch_data[15:0];
  // shift out popped entries, then append pushed halfwords behind the survivors
  always_comb begin
    sh[0] = n_pop == 2'd0 ? hw[0] : n_pop == 2'd1 ? hw[1] : hw[2];
    sh[1] = n_pop == 2'd0 ? hw[1] : n_pop == 2'd1 ? hw[2] : '0;
    sh[2] = n_pop == 2'd0 ? hw[2] : '0;
    for (int i = 0; i < DEPTH; i++)
      nx[i] = (n_push != 2'd0 && base == 2'(i)) ? first :
              (n_push == 2'd2 && base1 == 2'(i)) ? fetch_data[31:16] : sh[i];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) hw[i] <= '0;
      count <= '0;
      pc <= {RESET_PC[31:1], 1'b0};
      skip_low <= RESET_PC[1];
    end else if (redirect) begin
      count <= '0;
      pc <= {redirect_pc[31:1], 1'b0};
      skip_low <= redirect_pc[1];
    end else begin
      for (int i = 0; i < DEPTH; i++) hw[i] <= nx[i];
      count <= count + n_push - n_pop;
      pc <= pc + (pop_fire ? (comp ? 32'd2 : 32'd4) : 32'd0);
      if (push_fire) skip_low <= 1'b0;
    end
  end
endmodule

// File: tb/tb_instr_align.sv
// tb_instr_align: directed checks of the instruction aligner.
module tb_instr_align;
  logic clk = 0, rst_n = 0, redirect = 0, fetch_valid = 0, instr_ready = 0;
  logic [31:0] redirect_pc = 0, fetch_data = 0;
  logic fetch_ready, instr_valid, instr_compressed;
  logic [31:0] instr_out, instr_pc;
  int checks = 0, failures = 0;

  instr_align #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .redirect(redirect), .redirect_pc(redirect_pc),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_data(fetch_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_out(instr_out),
    .instr_pc(instr_pc), .instr_compressed(instr_compressed)
  );

  always #5 clk = ~clk;

  // {valid, compressed, pc, out}
  function automatic logic [65:0] obs();
    return {instr_valid, instr_compressed, instr_pc, instr_out};
  endfunction

  task automatic do_reset();
    rst_n = 0; redirect = 0; fetch_valid = 0; instr_ready = 0; fetch_data = 0; redirect_pc = 0;
    @(negedge clk); @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    #1;
    checks++; if ({fetch_ready, instr_valid} !== 2'b00) begin failures++; $display("FAIL reset_hs got=%b exp=00", {fetch_ready, instr_valid}); end
    checks++; if ({instr_pc, instr_out} !== 64'h0) begin failures++; $display("FAIL reset_pc_out got=%h exp=0", {instr_pc, instr_out}); end
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    #1;
    checks++; if ({fetch_ready, instr_valid} !== 2'b10) begin failures++; $display("FAIL reset_release got=%b exp=10", {fetch_ready, instr_valid}); end
    @(negedge clk);
  endtask

  task automatic test_basic();
    do_reset();
    instr_ready = 1; fetch_valid = 1; fetch_data = 32'h0000_0013;
    #1;
    checks++; if ({fetch_ready, instr_valid} !== 2'b10) begin failures++; $display("FAIL basic_first got=%b exp=10", {fetch_ready, instr_valid}); end
    @(negedge clk);
    fetch_data = 32'h0010_0093;
    #1;
    checks++; if (obs() !== {1'b1, 1'b0, 32'h0, 32'h0000_0013}) begin failures++; $display("FAIL basic_i0 got=%h exp=%h", obs(), {1'b1, 1'b0, 32'h0, 32'h0000_0013}); end
    checks++; if (fetch_ready !== 1'b0) begin failures++; $display("FAIL basic_fr_full got=%b exp=0", fetch_ready); end
    @(negedge clk);
    #1;
    checks++; if ({fetch_ready, instr_valid} !== 2'b10) begin failures++; $display("FAIL basic_empty got=%b exp=10", {fetch_ready, instr_valid}); end
    @(negedge clk);
    fetch_valid = 0;
    #1;
    checks++; if (obs() !== {1'b1, 1'b0, 32'h4, 32'h0010_0093}) begin failures++; $display("FAIL basic_i1 got=%h exp=%h", obs(), {1'b1, 1'b0, 32'h4, 32'h0010_0093}); end
    @(negedge clk);
    #1;
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL basic_drain got=%b exp=0", instr_valid); end
  endtask

  task automatic test_compressed();
    do_reset();
    instr_ready = 1; fetch_valid = 1; fetch_data = 32'h4501_4581;
    @(negedge clk);
    fetch_valid = 0;
    #1;
    checks++; if (obs() !== {1'b1, 1'b1, 32'h0, 32'h0000_4581}) begin failures++; $display("FAIL comp_i0 got=%h exp=%h", obs(), {1'b1, 1'b1, 32'h0, 32'h0000_4581}); end
    @(negedge clk);
    #1;
    checks++; if (obs() !== {1'b1, 1'b1, 32'h2, 32'h0000_4501}) begin failures++; $display("FAIL comp_i1 got=%h exp=%h", obs(), {1'b1, 1'b1, 32'h2, 32'h0000_4501}); end
    @(negedge clk);
    #1;
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL comp_drain got=%b exp=0", instr_valid); end
  endtask

  task automatic test_straddle();
    do_reset();
    instr_ready = 1; fetch_valid = 1; fetch_data = 32'h0013_4505;
    @(negedge clk);
    fetch_valid = 0;
    #1;
    checks++; if (obs() !== {1'b1, 1'b1, 32'h0, 32'h0000_4505}) begin failures++; $display("FAIL strad_i0 got=%h exp=%h", obs(), {1'b1, 1'b1, 32'h0, 32'h0000_4505}); end
    @(negedge clk);
    #1;
    checks++; if ({fetch_ready, instr_valid} !== 2'b10) begin failures++; $display("FAIL strad_hold got=%b exp=10", {fetch_ready, instr_valid}); end
    fetch_valid = 1; fetch_data = 32'hABCD_0000;
    @(negedge clk);
    fetch_valid = 0;
    #1;
    checks++; if (obs() !== {1'b1, 1'b0, 32'h2, 32'h0000_0013}) begin failures++; $display("FAIL strad_i1 got=%h exp=%h", obs(), {1'b1, 1'b0, 32'h2, 32'h0000_0013}); end
    @(negedge clk);
    #1;
    checks++; if (obs() !== {1'b1, 1'b1, 32'h6, 32'h0000_ABCD}) begin failures++; $display("FAIL strad_i2 got=%h exp=%h", obs(), {1'b1, 1'b1, 32'h6, 32'h0000_ABCD}); end
    @(negedge clk);
  endtask

  task automatic test_redirect_skip(input logic [31:0] rpc, input logic [31:0] next_pc);
    do_reset();
    redirect = 1; redirect_pc = rpc; instr_ready = 1;
    #1;
    checks++; if ({fetch_ready, instr_valid} !== 2'b00) begin failures++; $display("FAIL redir_block got=%b exp=00", {fetch_ready, instr_valid}); end
    @(negedge clk);
    redirect = 0; fetch_valid = 1; fetch_data = 32'h4581_0001;
    @(negedge clk);
    fetch_valid = 0;
    #1;
    checks++; if (obs() !== {1'b1, 1'b1, {rpc[31:1], 1'b0}, 32'h0000_4581}) begin failures++; $display("FAIL redir_i0 got=%h exp=%h", obs(), {1'b1, 1'b1, {rpc[31:1], 1'b0}, 32'h0000_4581}); end
    @(negedge clk);
    #1;
    checks++; if ({instr_valid, instr_pc} !== {1'b0, next_pc}) begin failures++; $display("FAIL redir_after got=%h exp=%h", {instr_valid, instr_pc}, {1'b0, next_pc}); end
    @(negedge clk);
  endtask

  task automatic test_back_pressure();
    do_reset();
    fetch_valid = 1; fetch_data = 32'h0013_4505;
    @(negedge clk);
    fetch_valid = 0; instr_ready = 1;
    @(negedge clk);
    instr_ready = 0; fetch_valid = 1; fetch_data = 32'hABCD_0000;
    @(negedge clk);
    fetch_data = 32'hFFFF_FFFF;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++; if ({fetch_ready, obs()} !== {1'b0, 1'b1, 1'b0, 32'h2, 32'h0000_0013}) begin failures++; $display("FAIL bp_hold%0d got=%h exp=%h", i, {fetch_ready, obs()}, {1'b0, 1'b1, 1'b0, 32'h2, 32'h0000_0013}); end
      @(negedge clk);
    end
    fetch_valid = 0; instr_ready = 1;
    #1;
    checks++; if (obs() !== {1'b1, 1'b0, 32'h2, 32'h0000_0013}) begin failures++; $display("FAIL bp_i0 got=%h exp=%h", obs(), {1'b1, 1'b0, 32'h2, 32'h0000_0013}); end
    @(negedge clk);
    #1;
    checks++; if ({fetch_ready, obs()} !== {1'b1, 1'b1, 1'b1, 32'h6, 32'h0000_ABCD}) begin failures++; $display("FAIL bp_i1 got=%h exp=%h", {fetch_ready, obs()}, {1'b1, 1'b1, 1'b1, 32'h6, 32'h0000_ABCD}); end
    @(negedge clk);
    #1;
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%b exp=0", instr_valid); end
  endtask

  task automatic test_redirect_priority();
    do_reset();
    instr_ready = 1; fetch_valid = 1; fetch_data = 32'h0013_4505;
    @(negedge clk);
    redirect = 1; redirect_pc = 32'h200; fetch_data = 32'h0000_0013;
    #1;
    checks++; if ({fetch_ready, instr_valid} !== 2'b00) begin failures++; $display("FAIL prio_block got=%b exp=00", {fetch_ready, instr_valid}); end
    @(negedge clk);
    redirect = 0; fetch_valid = 0;
    #1;
    checks++; if ({fetch_ready, instr_valid, instr_pc} !== {2'b10, 32'h200}) begin failures++; $display("FAIL prio_flush got=%h exp=%h", {fetch_ready, instr_valid, instr_pc}, {2'b10, 32'h200}); end
    fetch_valid = 1; fetch_data = 32'h0013_0000; instr_ready = 0;
    @(negedge clk);
    fetch_valid = 0;
    #1;
    checks++; if (obs() !== {1'b1, 1'b1, 32'h200, 32'h0}) begin failures++; $display("FAIL prio_load got=%h exp=%h", obs(), {1'b1, 1'b1, 32'h200, 32'h0}); end
    rst_n = 0;
    #1;
    checks++; if ({fetch_ready, instr_valid, instr_pc} !== {2'b00, 32'h0}) begin failures++; $display("FAIL prio_rst got=%h exp=%h", {fetch_ready, instr_valid, instr_pc}, {2'b00, 32'h0}); end
    @(negedge clk);
    rst_n = 1; instr_ready = 1;
    #1;
    checks++; if ({fetch_ready, instr_valid, instr_pc} !== {2'b10, 32'h0}) begin failures++; $display("FAIL prio_rel got=%h exp=%h", {fetch_ready, instr_valid, instr_pc}, {2'b10, 32'h0}); end
    @(negedge clk);
    #1;
    checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL prio_nopartial got=%b exp=0", instr_valid); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_compressed();
    test_straddle();
    test_redirect_skip(32'h0000_0102, 32'h0000_0104);
    test_redirect_skip(32'hFFFF_FFFF, 32'h0000_0000);
    test_back_pressure();
    test_redirect_priority();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
